// File: rtl/gear_resistance_driver_pkg.sv
// Shared types and sizing helpers for the gear resistance actuator driver.
// No logic of its own; zero latency.
// No flow control; constants and types only.
package gear_resistance_driver_pkg;

    localparam int GEAR_W = 4;

    typedef enum logic [2:0] {
        HOME,
        IDLE,
        DRIVE_UP,
        DRIVE_DOWN,
        BRAKE,
        FAULT
    } state_t;

    // One counter serves both the pulse watchdog and the settle dead time.
    function automatic int timer_width(input int timeout_cycles, input int settle_cycles);
        int longest;
        longest = (timeout_cycles > settle_cycles) ? timeout_cycles : settle_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/gear_resistance_driver_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with a registered rising-edge strobe.
// Level valid 2 cycles after the pin, rise strobe 3 cycles after the pin.
// No flow control; free-running sampler.
module gear_resistance_driver_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic meta_ff;
    logic sync_ff;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_ff <= 1'b0;
            sync_ff <= 1'b0;
            sync_q  <= 1'b0;
            rise    <= 1'b0;
        end else begin
            meta_ff <= async_in;
            sync_ff <= meta_ff;
            sync_q  <= sync_ff;
            rise    <= sync_ff & ~sync_q;
        end
    end

    assign level = sync_ff;

endmodule

// File: rtl/gear_resistance_driver.sv
// Drives the resistance actuator until encoder feedback shows it sits at the requested BCD gear.
// Motor responds the cycle after a target change; pulse feedback acts 3 cycles after the pin.
// No flow control; new targets are only accepted in IDLE, otherwise re-checked at each gear boundary.
module gear_resistance_driver
    import gear_resistance_driver_pkg::*;
#(
    parameter int MAX_GEAR        = 9,
    parameter int PULSES_PER_GEAR = 4,
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int SETTLE_CYCLES   = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GEAR_W-1:0] target_gear,
    input  logic              pos_pulse,
    input  logic              home_sw,
    output logic              motor_up,
    output logic              motor_down,
    output logic [GEAR_W-1:0] cur_gear,
    output logic              busy,
    output logic              fault
);

    localparam int TIMER_W = timer_width(TIMEOUT_CYCLES, SETTLE_CYCLES);
    localparam int CNT_W   = (PULSES_PER_GEAR > 1) ? $clog2(PULSES_PER_GEAR) : 1;

    localparam logic [GEAR_W-1:0]  MAX_G        = GEAR_W'(MAX_GEAR);
    localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(PULSES_PER_GEAR - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);

    state_t             state, state_nxt;
    logic [GEAR_W-1:0]  gear_nxt;
    logic [CNT_W-1:0]   pulse_cnt, cnt_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               pulse_evt;
    logic               home_lvl;
    logic               home_rise_unused;
    logic               target_ok;

    gear_resistance_driver_sync_edge u_pulse_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pos_pulse),
        .level    (),
        .rise     (pulse_evt)
    );

    gear_resistance_driver_sync_edge u_home_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (home_sw),
        .level    (home_lvl),
        .rise     (home_rise_unused)
    );

    assign target_ok = (target_gear <= MAX_G);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HOME;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gear_nxt  = cur_gear;
        cnt_nxt   = pulse_cnt;
        timer_nxt = timer;
        case (state)
            HOME: begin
                if (home_lvl) begin
                    gear_nxt  = '0;
                    cnt_nxt   = '0;
                    timer_nxt = '0;
                    state_nxt = BRAKE;
                end else if (timer == TIMEOUT_LAST) begin
                    timer_nxt = '0;
                    state_nxt = FAULT;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            IDLE: begin
                timer_nxt = '0;
                if (target_ok && (target_gear > cur_gear)) begin
                    state_nxt = DRIVE_UP;
                end else if (target_ok && (target_gear < cur_gear)) begin
                    state_nxt = DRIVE_DOWN;
                end
            end
            DRIVE_UP: begin
                // A pulse arriving on the timeout cycle still counts as progress.
                if (pulse_evt) begin
                    timer_nxt = '0;
                    if (pulse_cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        if (cur_gear != MAX_G) begin
                            gear_nxt = cur_gear + 1'b1;
                        end
                        if (!target_ok || (target_gear <= gear_nxt) || (gear_nxt == MAX_G)) begin
                            state_nxt = BRAKE;
                        end
                    end else begin
                        cnt_nxt = pulse_cnt + 1'b1;
                    end
                end else if (timer == TIMEOUT_LAST) begin
                    timer_nxt = '0;
                    state_nxt = FAULT;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            DRIVE_DOWN: begin
                // The home switch is absolute position, so it overrides the pulse count.
                if (home_lvl) begin
                    gear_nxt  = '0;
                    cnt_nxt   = '0;
                    timer_nxt = '0;
                    state_nxt = BRAKE;
                end else if (pulse_evt) begin
                    timer_nxt = '0;
                    if (pulse_cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        if (cur_gear != '0) begin
                            gear_nxt = cur_gear - 1'b1;
                        end
                        if (!target_ok || (target_gear >= gear_nxt)) begin
                            state_nxt = BRAKE;
                        end
                    end else begin
                        cnt_nxt = pulse_cnt + 1'b1;
                    end
                end else if (timer == TIMEOUT_LAST) begin
                    timer_nxt = '0;
                    state_nxt = FAULT;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            BRAKE: begin
                if (timer == SETTLE_LAST) begin
                    timer_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            FAULT: begin
                timer_nxt = '0;
            end
            default: begin
                timer_nxt = '0;
                state_nxt = FAULT;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_gear   <= '0;
            pulse_cnt  <= '0;
            timer      <= '0;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            busy       <= 1'b1;
            fault      <= 1'b0;
        end else begin
            cur_gear   <= gear_nxt;
            pulse_cnt  <= cnt_nxt;
            timer      <= timer_nxt;
            motor_up   <= (state_nxt == DRIVE_UP);
            motor_down <= (state_nxt == DRIVE_DOWN) || (state_nxt == HOME);
            busy       <= (state_nxt != IDLE);
            fault      <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_gear_resistance_driver.sv
// Randomised and directed checks of gear_resistance_driver against a behavioural model of the actuator rules.
module tb_gear_resistance_driver;

    localparam int MAX_G  = 9;
    localparam int PPG    = 4;
    localparam int TMO    = 200;
    localparam int SETTLE = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pos_pulse = 1'b0;
    logic       home_sw = 1'b0;
    logic [3:0] target_gear = 4'd0;
    logic       motor_up, motor_down, busy, fault;
    logic [3:0] cur_gear;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gear_resistance_driver #(
        .MAX_GEAR        (MAX_G),
        .PULSES_PER_GEAR (PPG),
        .TIMEOUT_CYCLES  (TMO),
        .SETTLE_CYCLES   (SETTLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .target_gear (target_gear),
        .pos_pulse   (pos_pulse),
        .home_sw     (home_sw),
        .motor_up    (motor_up),
        .motor_down  (motor_down),
        .cur_gear    (cur_gear),
        .busy        (busy),
        .fault       (fault)
    );

    // Behavioural model: phase, gear, pulses since last boundary, quiet time, settle time left.
    localparam int P_HOME = 0, P_IDLE = 1, P_UP = 2, P_DOWN = 3, P_SETTLE = 4, P_FAULT = 5;
    int ph = P_HOME;
    int g = 0;
    int steps = 0;
    int quiet = 0;
    int settle_left = 0;
    bit in_rst = 1'b1;
    bit started = 1'b0;
    bit hp[5];   // hp[k] = pulse pin k edges ago
    bit hh[3];   // hh[k] = home pin k edges ago

    always @(posedge clk) begin : model
        bit home_seen, pulse_seen, tv;
        started = 1'b1;
        if (reset) begin
            ph = P_HOME; g = 0; steps = 0; quiet = 0; settle_left = 0; in_rst = 1'b1;
            for (int k = 0; k < 5; k++) hp[k] = 1'b0;
            for (int k = 0; k < 3; k++) hh[k] = 1'b0;
        end else begin
            in_rst     = 1'b0;
            home_seen  = hh[2];
            pulse_seen = hp[3] && !hp[4];
            tv         = (int'(target_gear) <= MAX_G);
            case (ph)
                P_HOME: begin
                    if (home_seen) begin
                        g = 0; steps = 0; ph = P_SETTLE; settle_left = SETTLE;
                    end else begin
                        quiet++;
                        if (quiet >= TMO) ph = P_FAULT;
                    end
                end
                P_IDLE: begin
                    quiet = 0;
                    if (tv && int'(target_gear) > g) ph = P_UP;
                    else if (tv && int'(target_gear) < g) ph = P_DOWN;
                end
                P_UP: begin
                    if (pulse_seen) begin
                        quiet = 0; steps++;
                        if (steps == PPG) begin
                            steps = 0;
                            if (g < MAX_G) g++;
                            if (!(tv && int'(target_gear) > g) || g == MAX_G) begin
                                ph = P_SETTLE; settle_left = SETTLE;
                            end
                        end
                    end else begin
                        quiet++;
                        if (quiet >= TMO) ph = P_FAULT;
                    end
                end
                P_DOWN: begin
                    if (home_seen) begin
                        g = 0; steps = 0; quiet = 0; ph = P_SETTLE; settle_left = SETTLE;
                    end else if (pulse_seen) begin
                        quiet = 0; steps++;
                        if (steps == PPG) begin
                            steps = 0;
                            if (g > 0) g--;
                            if (!(tv && int'(target_gear) < g)) begin
                                ph = P_SETTLE; settle_left = SETTLE;
                            end
                        end
                    end else begin
                        quiet++;
                        if (quiet >= TMO) ph = P_FAULT;
                    end
                end
                P_SETTLE: begin
                    quiet = 0;
                    settle_left--;
                    if (settle_left == 0) ph = P_IDLE;
                end
                default: ;
            endcase
            for (int k = 4; k > 1; k--) hp[k] = hp[k-1];
            hp[1] = pos_pulse;
            hh[2] = hh[1];
            hh[1] = home_sw;
        end
    end

    always @(negedge clk) begin : compare
        logic [7:0] exp_v, got_v;
        if (started) begin
            if (in_rst) exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
            else exp_v = {ph == P_UP, (ph == P_DOWN) || (ph == P_HOME), ph != P_IDLE, ph == P_FAULT, 4'(g)};
            got_v = {motor_up, motor_down, busy, fault, cur_gear};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL model_cycle t=%0t up/dn/busy/flt/gear got=%b expected=%b", $time, got_v, exp_v);
            end
            n_cmp++;
            if (motor_up === 1'b1 && motor_down === 1'b1) begin
                n_bad++;
                $display("FAIL both_motors t=%0t got up=1 dn=1 required not both", $time);
            end
        end
    end

    task automatic expect_val(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic pulse(input int gap);
        pos_pulse = 1'b1;
        repeat (2) @(negedge clk);
        pos_pulse = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n, m, r;
        repeat (3) @(negedge clk);
        expect_val("rst_motor_up", int'(motor_up), 0);
        expect_val("rst_motor_down", int'(motor_down), 0);
        expect_val("rst_busy", int'(busy), 1);
        expect_val("rst_fault", int'(fault), 0);
        expect_val("rst_gear", int'(cur_gear), 0);
        reset = 1'b0;
        @(negedge clk);
        expect_val("home_motor_down", int'(motor_down), 1);

        // 1: homing
        repeat (50) @(negedge clk);
        home_sw = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (motor_down && n < 100);
        expect_val("home_drop_latency", n, 3);
        m = 0;
        do begin @(negedge clk); m++; end while (busy && m < 100);
        expect_val("home_settle_cycles", m, 10);
        expect_val("home_gear", int'(cur_gear), 0);

        // 2: up move to gear 3
        target_gear = 4'd3;
        @(negedge clk);
        expect_val("up_motor_start", int'(motor_up), 1);
        home_sw = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            pulse(20);
            if (i % 4 == 0) expect_val("up_gear_step", int'(cur_gear), i / 4);
        end
        expect_val("up_motor_stop", int'(motor_up), 0);
        expect_val("up_busy_done", int'(busy), 0);

        // 6: down from 3 with home resync, pulse and home coinciding
        target_gear = 4'd0;
        pulse(20);
        pulse(20);
        pos_pulse = 1'b1;
        @(negedge clk);
        home_sw = 1'b1;
        @(negedge clk);
        pos_pulse = 1'b0;
        repeat (30) @(negedge clk);
        expect_val("homedown_gear", int'(cur_gear), 0);
        expect_val("homedown_fault", int'(fault), 0);
        expect_val("homedown_busy", int'(busy), 0);

        // 3: retarget mid-move and reverse
        target_gear = 4'd5;
        @(negedge clk);
        home_sw = 1'b0;
        for (int i = 1; i <= 6; i++) pulse(20);
        target_gear = 4'd1;
        pulse(20);
        pulse(20);
        expect_val("rev_gear_boundary", int'(cur_gear), 2);
        expect_val("rev_motor_up_off", int'(motor_up), 0);
        expect_val("rev_motor_down_on", int'(motor_down), 1);
        for (int i = 1; i <= 4; i++) pulse(20);
        expect_val("rev_gear_final", int'(cur_gear), 1);
        expect_val("rev_motor_down_off", int'(motor_down), 0);

        // 4: invalid BCD at gear 2
        target_gear = 4'd2;
        for (int i = 1; i <= 4; i++) pulse(20);
        target_gear = 4'hC;
        repeat (30) @(negedge clk);
        expect_val("bcd_gear", int'(cur_gear), 2);
        expect_val("bcd_busy", int'(busy), 0);
        expect_val("bcd_motors", int'({motor_up, motor_down}), 0);

        // 5: timeout
        target_gear = 4'd4;
        n = 0; m = 0;
        do begin @(negedge clk); if (motor_up) n++; m++; end while (!fault && m < 500);
        expect_val("tmo_up_cycles", n, 200);
        pulse(10);
        target_gear = 4'd1;
        repeat (20) @(negedge clk);
        expect_val("tmo_fault_held", int'(fault), 1);
        expect_val("tmo_motors", int'({motor_up, motor_down}), 0);
        expect_val("tmo_busy", int'(busy), 1);

        // 7: reset mid-move
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        home_sw = 1'b1;
        repeat (20) @(negedge clk);
        target_gear = 4'd3;
        home_sw = 1'b0;
        for (int i = 1; i <= 5; i++) pulse(10);
        expect_val("mid_gear", int'(cur_gear), 1);
        reset = 1'b1;
        @(negedge clk);
        expect_val("mid_rst_motors", int'({motor_up, motor_down}), 0);
        expect_val("mid_rst_gear", int'(cur_gear), 0);
        reset = 1'b0;
        @(negedge clk);
        expect_val("mid_rst_home_down", int'(motor_down), 1);

        // Randomised traffic
        home_sw = 1'b1;
        repeat (20) @(negedge clk);
        home_sw = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ph == P_FAULT) begin
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                home_sw = 1'b1;
                repeat (20) @(negedge clk);
                home_sw = 1'b0;
            end
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                target_gear = 4'($urandom_range(0, 15));
                @(negedge clk);
            end else if (r <= 7) begin
                pulse($urandom_range(3, 25));
            end else if (r == 8) begin
                home_sw = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                home_sw = 1'b0;
                @(negedge clk);
            end else begin
                repeat ($urandom_range(1, 40)) @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
